// File: rtl/fb_port_arbiter.sv
// Frame-RAM port arbiter: VGA scan-out reads take every active-video cycle; queued pixel writes drain in blanking.
// Optional FB_ARB_CLIP_COUNT_EN adds a saturating counter of discarded out-of-range writes.
module fb_port_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_vga,
    input  logic                          vga_reset,
    input  logic [9:0]                    next_x,
    input  logic [9:0]                    next_y,
    output logic [DATA_W-1:0]             pix_out,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [9:0]                    wr_x,
    input  logic [9:0]                    wr_y,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_q,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_start,
    output logic [15:0]                   clip_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    typedef enum logic [1:0] {G_NONE, G_READ, G_WRITE} grant_t;

    grant_t grant_q, grant_d;

    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [LVL_W-1:0]  count;

    logic read_slot, fifo_empty, fifo_full;
    logic wr_in_range, accept, push, pop;
    logic at_origin, at_origin_q;

    // 640-wide lines: y*640 = (y<<9) + (y<<7)
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(y);
        return (yy << 9) + (yy << 7) + ADDR_W'(x);
    endfunction

    always_comb begin
        read_slot   = (next_x < H_LIM) && (next_y < V_LIM);
        at_origin   = (next_x == 10'd0) && (next_y == 10'd0);
        fifo_empty  = (count == '0);
        fifo_full   = (count == FULL_LVL);
        wr_ready    = !fifo_full && !vga_reset;
        wr_in_range = (wr_x < H_LIM) && (wr_y < V_LIM);
        accept      = wr_valid && wr_ready;
        push        = accept && wr_in_range;
        pop         = !read_slot && !fifo_empty && !vga_reset;

        mem_we    = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        if (read_slot) begin
            mem_addr = pix_addr(next_x, next_y);
        end else if (pop) begin
            mem_addr  = q_addr[rd_ptr];
            mem_wdata = q_data[rd_ptr];
        end

        grant_d = read_slot ? G_READ : G_WRITE;
        pix_out = (grant_q == G_READ) ? mem_q : '0;
    end

    always_ff @(posedge clk_vga) begin
        if (vga_reset) begin
            grant_q     <= G_NONE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            at_origin_q <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            grant_q <= grant_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            at_origin_q <= at_origin;
            frame_start <= at_origin && !at_origin_q;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (push) begin
            q_addr[wr_ptr] <= pix_addr(wr_x, wr_y);
            q_data[wr_ptr] <= wr_data;
        end
    end

    assign fifo_level = count;

`ifdef FB_ARB_CLIP_COUNT_EN
    always_ff @(posedge clk_vga) begin
        if (vga_reset)
            clip_cnt <= '0;
        else if (accept && !wr_in_range && clip_cnt != '1)
            clip_cnt <= clip_cnt + 1'b1;
    end
`else
    assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fb_port_arbiter;

    logic        clk_vga = 1'b0;
    logic        vga_reset;
    logic [9:0]  next_x, next_y;
    logic [7:0]  pix_out;
    logic        wr_valid, wr_ready;
    logic [9:0]  wr_x, wr_y;
    logic [7:0]  wr_data;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_q;
    logic [2:0]  fifo_level;
    logic        frame_start;
    logic [15:0] clip_cnt;

`ifdef FB_ARB_CLIP_COUNT_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    always #5 clk_vga = ~clk_vga;

    fb_port_arbiter #(
        .H_ACTIVE(640), .V_ACTIVE(480), .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)
    ) dut (
        .clk_vga(clk_vga), .vga_reset(vga_reset),
        .next_x(next_x), .next_y(next_y), .pix_out(pix_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .fifo_level(fifo_level), .frame_start(frame_start), .clip_cnt(clip_cnt)
    );

    // Reference model: pending writes as a queue of linear addresses, plus previous-cycle facts.
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t mq[$];
    bit  m_prev_read   = 1'b0;
    bit  m_prev_origin = 1'b0;
    bit  m_frame       = 1'b0;
    int  m_clip        = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    // Apply the coming clock edge to the model, then move past the edge.
    task automatic advance();
        int sz;
        bit rd, org;
        sz  = mq.size();
        rd  = (next_x < 10'd640) && (next_y < 10'd480);
        org = (next_x == 10'd0) && (next_y == 10'd0);
        if (vga_reset) begin
            mq.delete();
            m_prev_read   = 1'b0;
            m_prev_origin = 1'b0;
            m_frame       = 1'b0;
            m_clip        = 0;
        end else begin
            if (wr_valid && sz < 4) begin
                if (wr_x < 10'd640 && wr_y < 10'd480)
                    mq.push_back('{addr: int'(wr_y) * 640 + int'(wr_x), data: int'(wr_data)});
                else if (m_clip < 65535)
                    m_clip++;
            end
            if (!rd && sz > 0) mq.delete(0);
            m_frame       = org && !m_prev_origin;
            m_prev_origin = org;
            m_prev_read   = rd;
        end
        @(posedge clk_vga);
        #1;
    endtask

    task automatic test_reset();
        vga_reset = 1'b1; next_x = 10'd100; next_y = 10'd100;
        mem_q = 8'hFF; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        advance();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_x = 10'(i);
            @(negedge clk_vga);
            n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%b exp=0", mem_we); end
            n_cmp++; if (pix_out !== 8'h00) begin n_bad++; $display("FAIL rst_pix got=%h exp=00", pix_out); end
            n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", wr_ready); end
            n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
            advance();
        end
        vga_reset = 1'b0; wr_valid = 1'b0;
        @(negedge clk_vga);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got=%b exp=1", wr_ready); end
        n_cmp++; if (pix_out !== 8'h00) begin n_bad++; $display("FAIL rel_pix got=%h exp=00", pix_out); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rel_frame got=%b exp=0", frame_start); end
        n_cmp++; if (clip_cnt !== 16'd0) begin n_bad++; $display("FAIL rel_clip got=%0d exp=0", clip_cnt); end
        advance();
    endtask

    task automatic test_scan_read();
        wr_valid = 1'b0; next_x = 10'd5; next_y = 10'd2; mem_q = 8'h00;
        @(negedge clk_vga);
        n_cmp++; if (mem_addr !== 19'd1285) begin n_bad++; $display("FAIL scan_addr got=%0d exp=1285", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL scan_we got=%b exp=0", mem_we); end
        advance();
        next_x = 10'd700; mem_q = 8'hA5;
        @(negedge clk_vga);
        n_cmp++; if (pix_out !== 8'hA5) begin n_bad++; $display("FAIL scan_pix got=%h exp=a5", pix_out); end
        n_cmp++; if (mem_addr !== 19'd0) begin n_bad++; $display("FAIL blank_addr got=%0d exp=0", mem_addr); end
        advance();
        next_x = 10'd10; mem_q = 8'h77;
        @(negedge clk_vga);
        n_cmp++; if (pix_out !== 8'h00) begin n_bad++; $display("FAIL blank_pix got=%h exp=00", pix_out); end
        advance();
    endtask

    task automatic test_backpressure();
        int acc = 0, late_rdy = 0, saw_we = 0;
        bit hs;
        next_x = 10'd10; next_y = 10'd10;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_x = 10'(acc + 3); wr_y = 10'd1; wr_data = 8'(8'h10 + acc);
            @(negedge clk_vga);
            hs = wr_ready;
            if (mem_we) saw_we++;
            if (i >= 4 && wr_ready) late_rdy++;
            advance();
            if (hs) acc++;
        end
        wr_valid = 1'b0;
        @(negedge clk_vga);
        n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
        n_cmp++; if (late_rdy != 0) begin n_bad++; $display("FAIL bp_ready_full got=%0d exp=0", late_rdy); end
        n_cmp++; if (saw_we != 0) begin n_bad++; $display("FAIL bp_we_active got=%0d exp=0", saw_we); end
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
        advance();
        next_x = 10'd640;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_vga);
            n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL drain_we[%0d] got=%b exp=1", k, mem_we); end
            n_cmp++; if (mem_addr !== 19'(643 + k)) begin n_bad++; $display("FAIL drain_addr[%0d] got=%0d exp=%0d", k, mem_addr, 643 + k); end
            n_cmp++; if (mem_wdata !== 8'(8'h10 + k)) begin n_bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, mem_wdata, 8'(8'h10 + k)); end
            advance();
        end
        @(negedge clk_vga);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL drain_done_we got=%b exp=0", mem_we); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL drain_done_level got=%0d exp=0", fifo_level); end
        advance();
    endtask

    task automatic test_write_addr();
        next_x = 10'd650; next_y = 10'd10;
        wr_valid = 1'b1; wr_x = 10'd639; wr_y = 10'd479; wr_data = 8'h3C;
        @(negedge clk_vga);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL wa_ready got=%b exp=1", wr_ready); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL wa_early_we got=%b exp=0", mem_we); end
        advance();
        wr_valid = 1'b0;
        @(negedge clk_vga);
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wa_we got=%b exp=1", mem_we); end
        n_cmp++; if (mem_addr !== 19'd307199) begin n_bad++; $display("FAIL wa_addr got=%0d exp=307199", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'h3C) begin n_bad++; $display("FAIL wa_data got=%h exp=3c", mem_wdata); end
        advance();
        @(negedge clk_vga);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL wa_after_we got=%b exp=0", mem_we); end
        advance();
    endtask

    task automatic test_clip();
        next_x = 10'd700; next_y = 10'd0;
        wr_valid = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 8'h11;
        @(negedge clk_vga);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL clip_ready0 got=%b exp=1", wr_ready); end
        advance();
        wr_x = 10'd0; wr_y = 10'd480; wr_data = 8'h22;
        @(negedge clk_vga);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL clip_ready1 got=%b exp=1", wr_ready); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL clip_we0 got=%b exp=0", mem_we); end
        advance();
        wr_valid = 1'b0;
        @(negedge clk_vga);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL clip_we1 got=%b exp=0", mem_we); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL clip_level got=%0d exp=0", fifo_level); end
        n_cmp++; if (clip_cnt !== 16'(CLIP_EN ? 2 : 0)) begin n_bad++; $display("FAIL clip_cnt got=%0d exp=%0d", clip_cnt, CLIP_EN ? 2 : 0); end
        advance();
    endtask

    task automatic test_frame_and_reset();
        int fx[4] = '{799, 0, 0, 1};
        int fy[4] = '{524, 0, 0, 0};
        bit fe[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_x = 10'(fx[i]); next_y = 10'(fy[i]);
            @(negedge clk_vga);
            n_cmp++; if (frame_start !== fe[i]) begin n_bad++; $display("FAIL frame[%0d] got=%b exp=%b", i, frame_start, fe[i]); end
            advance();
        end
        next_x = 10'd20; next_y = 10'd20;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_x = 10'(i); wr_y = 10'd5; wr_data = 8'(i + 1);
            advance();
        end
        wr_valid = 1'b0;
        @(negedge clk_vga);
        n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL mid_level got=%0d exp=3", fifo_level); end
        advance();
        vga_reset = 1'b1; next_x = 10'd650;
        @(negedge clk_vga);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we got=%b exp=0", mem_we); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got=%b exp=0", wr_ready); end
        advance();
        vga_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_vga);
            n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL post_rst_we[%0d] got=%b exp=0", i, mem_we); end
            n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL post_rst_level[%0d] got=%0d exp=0", i, fifo_level); end
            advance();
        end
    endtask

    task automatic test_random();
        logic        e_rd, e_we, e_rdy, e_frm;
        logic [18:0] e_addr;
        logic [7:0]  e_pix, e_wd;
        logic [2:0]  e_lvl;
        logic [15:0] e_clip;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 5) begin
                next_x = 10'd0; next_y = 10'd0;
            end else begin
                next_x = 10'($urandom_range(0, 1000));
                next_y = 10'($urandom_range(0, 524));
            end
            vga_reset = ($urandom_range(0, 99) == 0);
            wr_valid  = 1'($urandom_range(0, 1));
            wr_x      = 10'($urandom_range(0, 700));
            wr_y      = 10'($urandom_range(0, 520));
            wr_data   = 8'($urandom);
            mem_q     = 8'($urandom);
            @(negedge clk_vga);
            e_rd   = (next_x < 10'd640) && (next_y < 10'd480);
            e_we   = !vga_reset && !e_rd && (mq.size() > 0);
            e_addr = e_rd ? 19'(int'(next_y) * 640 + int'(next_x)) : (e_we ? 19'(mq[0].addr) : 19'd0);
            e_wd   = e_we ? 8'(mq[0].data) : 8'h00;
            e_rdy  = !vga_reset && (mq.size() < 4);
            e_lvl  = 3'(mq.size());
            e_pix  = m_prev_read ? mem_q : 8'h00;
            e_frm  = m_frame;
            e_clip = CLIP_EN ? 16'(m_clip) : 16'd0;
            n_cmp++; if (mem_we !== e_we) begin n_bad++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, mem_we, e_we); end
            n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, mem_addr, e_addr); end
            if (e_we) begin
                n_cmp++; if (mem_wdata !== e_wd) begin n_bad++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, e_wd); end
            end
            n_cmp++; if (wr_ready !== e_rdy) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, wr_ready, e_rdy); end
            n_cmp++; if (fifo_level !== e_lvl) begin n_bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fifo_level, e_lvl); end
            n_cmp++; if (clip_cnt !== e_clip) begin n_bad++; $display("FAIL rnd_clip c=%0d got=%0d exp=%0d", c, clip_cnt, e_clip); end
            if (!vga_reset) begin
                n_cmp++; if (pix_out !== e_pix) begin n_bad++; $display("FAIL rnd_pix c=%0d got=%h exp=%h", c, pix_out, e_pix); end
                n_cmp++; if (frame_start !== e_frm) begin n_bad++; $display("FAIL rnd_frame c=%0d got=%b exp=%b", c, frame_start, e_frm); end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_scan_read();
        test_backpressure();
        test_write_addr();
        test_clip();
        test_frame_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
